pc_next_stage: RTL

- Program-counter stage directly downstream of the branch-decision AND gate.
- Consumes `pc_src` (branch & zero) and the branch target, holds the architectural PC, and issues fetch requests to instruction memory over a valid/ready handshake.
- Supplies `pc` and `pc_plus4` to the fetch and writeback paths.
- Traps misaligned branch targets.

---
 rtl/riscv_pc_pkg.sv | 19 +
 rtl/pc_stats_counter.sv | 22 ++
 rtl/pc_next_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_pc_pkg.sv
// Shared constants and state encoding for the program-counter stage.
//   XLEN             : datapath / PC width in bits
//   PC_STEP          : sequential PC increment in bytes
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   pc_state_t       : PC stage FSM states
package riscv_pc_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned PC_STEP          = 4;
    localparam int unsigned STATS_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        TRAP  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_stats_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
//   clk, rst_n : clock, async active-low reset (clears count)
//   inc        : count one event this cycle
//   count      : registered event count
module pc_stats_counter
    import riscv_pc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [STATS_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + STATS_W'(1);
        end
    end

endmodule

// File: rtl/pc_next_stage.sv
// Program-counter stage: holds the architectural PC, selects the next PC
// from the sequential increment or the taken-branch target, and issues fetch
// requests over a valid/ready handshake. Misaligned taken targets freeze the
// stage in TRAP until reset.
// Optional build macro PC_BRANCH_STATS_EN adds saturating accept counters.
//   clk, rst_n       : clock, async active-low reset
//   pc_src           : branch taken; selects branch_target on accept
//   branch_target    : branch adder output
//   stall            : hazard hold, overrides if_ready
//   if_ready         : instruction memory accepts the request
//   if_valid         : fetch request valid for pc
//   pc               : current PC / fetch address
//   pc_plus4         : pc + 4 (combinational, wraps modulo 2^XLEN)
//   misalign         : sticky misaligned-target trap flag
//   branch_taken_cnt : [PC_BRANCH_STATS_EN] aligned taken-branch accepts
//   fetch_cnt        : [PC_BRANCH_STATS_EN] all accepts
module pc_next_stage
    import riscv_pc_pkg::*;
#(
    parameter int unsigned             XLEN     = riscv_pc_pkg::XLEN,
    parameter logic [XLEN-1:0]         RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_src,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               stall,
    input  logic               if_ready,
    output logic               if_valid,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
`ifdef PC_BRANCH_STATS_EN
    output logic [STATS_W-1:0] branch_taken_cnt,
    output logic [STATS_W-1:0] fetch_cnt,
`endif
    output logic               misalign
);

    // Reject a misaligned reset vector at elaboration.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("pc_next_stage: RESET_PC must be 4-byte aligned");
    end

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_d;
    logic            accept;
    logic            target_aligned;

    assign accept         = if_valid & if_ready & ~stall;
    assign target_aligned = (branch_target[1:0] == 2'b00);
    assign pc_plus4       = pc + XLEN'(PC_STEP);

    // State, PC and decoded status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            if_valid <= (state_d == FETCH);
            misalign <= (state_d == TRAP);
        end
    end

    // Next-state and next-PC; pc_src only matters in an accept cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (accept) begin
                    if (!pc_src) begin
                        pc_d = pc_plus4;
                    end else if (target_aligned) begin
                        pc_d = branch_target;
                    end else begin
                        // PC stays on the faulting instruction.
                        state_d = TRAP;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

`ifdef PC_BRANCH_STATS_EN
    logic taken_inc;

    assign taken_inc = accept & pc_src & target_aligned;

    pc_stats_counter u_branch_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (taken_inc),
        .count (branch_taken_cnt)
    );

    pc_stats_counter u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .count (fetch_cnt)
    );
`endif

endmodule
